// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked sharing of one byte-wide UART transmitter among NUM_REQ requesters.
// Optional: define UART_ARB_TIMEOUT_EN to drop a stalled message lock after LOCK_TIMEOUT idle cycles.

module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned LOCK_TIMEOUT = 1024,
    parameter int unsigned BUSY_WAIT    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    input  logic                   tx_done,
    output logic                   arb_err,
    output logic                   timeout_o
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BW_W  = $clog2(BUSY_WAIT + 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || BUSY_WAIT < 1 || LOCK_TIMEOUT < 1) begin : g_bad_params
        $error("uart_tx_arbiter: NUM_REQ must be 2..8, BUSY_WAIT and LOCK_TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t             state;
    logic               lock;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [BW_W-1:0]    busy_cnt;

    logic               owner_valid;
    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic [7:0]         sel_data;
    logic               sel_last;
    int unsigned        best;
    int unsigned        off;
    logic               busy_expired;
    logic               byte_done;
    logic               lock_expired;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v[k] = (IDX_W'(k) == idx);
        end
        return v;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (32'(i) == NUM_REQ - 1) ? '0 : i + IDX_W'(1);
    endfunction

    // Pick the requester closest to rr_ptr in rotating order, or only the owner while locked.
    always_comb begin
        owner_valid = 1'b0;
        sel_valid   = 1'b0;
        sel_idx     = '0;
        sel_data    = '0;
        sel_last    = 1'b0;
        best        = NUM_REQ;
        off         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IDX_W'(k) == owner) owner_valid = req_valid[k];
        end
        if (rst_n && state == IDLE) begin
            if (lock) begin
                sel_valid = owner_valid;
                sel_idx   = owner;
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    off = (32'(k) >= 32'(rr_ptr)) ? 32'(k) - 32'(rr_ptr)
                                                 : 32'(k) + NUM_REQ - 32'(rr_ptr);
                    if (req_valid[k] && off < best) begin
                        best      = off;
                        sel_valid = 1'b1;
                        sel_idx   = IDX_W'(k);
                    end
                end
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IDX_W'(k) == sel_idx) begin
                sel_data = req_data[8*k +: 8];
                sel_last = req_last[k];
            end
        end
    end

    always_comb req_ready = sel_valid ? onehot(sel_idx) : '0;

    // A byte completes on tx_done, on a fast core skipping busy, or when busy never shows up.
    always_comb begin
        busy_expired = (busy_cnt == BW_W'(BUSY_WAIT - 1));
        byte_done    = ((state == WAIT_BUSY) && !tx_busy && (tx_done || busy_expired)) ||
                       ((state == WAIT_DONE) && tx_done);
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(LOCK_TIMEOUT + 1);

    logic [TO_W-1:0] lock_cnt;

    always_comb lock_expired = (state == IDLE) && lock && !owner_valid &&
                               (lock_cnt == TO_W'(LOCK_TIMEOUT - 1));

    // Counts idle cycles of a locked owner; any other situation restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt  <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= lock_expired;
            if ((state == IDLE) && lock && !owner_valid && !lock_expired) begin
                lock_cnt <= lock_cnt + TO_W'(1);
            end else begin
                lock_cnt <= '0;
            end
        end
    end
`else
    always_comb lock_expired = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            arb_err  <= 1'b0;
            lock     <= 1'b0;
            rr_ptr   <= '0;
            owner    <= '0;
            busy_cnt <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        tx_data  <= sel_data;
                        owner    <= sel_idx;
                        gnt      <= onehot(sel_idx);
                        lock     <= ~sel_last;
                        tx_start <= 1'b1;
                        state    <= START;
                    end else if (lock_expired) begin
                        lock   <= 1'b0;
                        gnt    <= '0;
                        rr_ptr <= next_idx(owner);
                    end
                end
                START: begin
                    busy_cnt <= '0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (busy_expired && !tx_done) begin
                        arb_err <= 1'b1;
                    end else begin
                        busy_cnt <= busy_cnt + BW_W'(1);
                    end
                end
                WAIT_DONE: begin
                end
                default: state <= IDLE;
            endcase
            // Pointer moves only at message end so a locked message is never interleaved.
            if (byte_done) begin
                state <= IDLE;
                if (!lock) begin
                    rr_ptr <= next_idx(owner);
                    gnt    <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte queues, a small transmitter model, event logs.
module tb_uart_tx_arbiter;

    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid;
    logic [8*NR-1:0]   req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     gnt;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic              tx_done;
    logic              arb_err;
    logic              timeout_o;

    uart_tx_arbiter #(.NUM_REQ(NR), .LOCK_TIMEOUT(8), .BUSY_WAIT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .gnt(gnt),
        .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done),
        .arb_err(arb_err), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int acc_cyc[64], acc_idx[64], acc_dat[64];
    int acc_n;
    int start_cyc[64], start_dat[64], start_gnt[64];
    int start_n;
    int done_c[64];
    int done_n;
    int err_cyc, to_cyc, to_n;
    logic [7:0] cur_dat;
    bit silent;
    int mcnt;
    int rr_r;

    logic [8:0] rmem[NR][8];
    int rhead[NR];
    int rtail[NR];

    int e2_idx[4] = '{0, 2, 0, 2};
    int e2_dat[4] = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
    int e3_idx[4] = '{3, 3, 3, 0};
    int e3_dat[4] = '{8'h10, 8'h11, 8'h12, 8'hC0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic l);
        rmem[i][rtail[i] % 8] = {l, d};
        rtail[i]++;
    endtask

    task automatic clr_logs();
        acc_n = 0; start_n = 0; done_n = 0;
        err_cyc = -1; to_cyc = -1; to_n = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clr_logs();
        for (int i = 0; i < NR; i++) begin
            rhead[i] = 0;
            rtail[i] = 0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_acc(input int n);
        int k;
        k = 0;
        while (acc_n < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("wait_accept", 32'(acc_n >= n), 1);
    endtask

    task automatic wait_done(input int n);
        int k;
        k = 0;
        while (done_n < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("wait_done", 32'(done_n >= n), 1);
    endtask

    // Requester side: present the head of each queue, pop on an accept pulse.
    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) begin
            req_valid[i]      = (rhead[i] != rtail[i]);
            req_data[8*i +: 8] = rmem[i][rhead[i] % 8][7:0];
            req_last[i]       = rmem[i][rhead[i] % 8][8];
        end
    end

    // Transmitter model: busy for three cycles after tx_start, then a done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            tx_busy = 1'b0;
            tx_done = 1'b0;
            mcnt    = 0;
        end else begin
            tx_done = 1'b0;
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    tx_busy = 1'b0;
                    tx_done = 1'b1;
                end
            end else if (tx_start && !silent) begin
                tx_busy = 1'b1;
                mcnt    = 3;
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (req_ready != '0 && acc_n < 64) begin
                for (int k = 0; k < NR; k++) begin
                    if (req_ready[k]) begin
                        acc_idx[acc_n] = k;
                        acc_dat[acc_n] = int'(req_data[8*k +: 8]);
                        rhead[k]++;
                    end
                end
                acc_cyc[acc_n] = cyc;
                acc_n++;
            end
            if (tx_start && start_n < 64) begin
                start_cyc[start_n] = cyc;
                start_dat[start_n] = int'(tx_data);
                start_gnt[start_n] = int'(gnt);
                start_n++;
                cur_dat = tx_data;
            end
            if (tx_done && done_n < 64) begin
                done_c[done_n] = cyc;
                done_n++;
                chk("tx_data_stable", 32'(tx_data), 32'(cur_dat));
            end
            if (arb_err && err_cyc < 0) err_cyc = cyc;
            if (timeout_o) begin
                to_n++;
                to_cyc = cyc;
            end
            chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
            chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
        end
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        silent = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;
        tx_busy = 1'b0; tx_done = 1'b0; mcnt = 0;
        for (int i = 0; i < NR; i++) begin
            rhead[i] = 0;
            rtail[i] = 0;
        end
        clr_logs();
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_arb_err", 32'(arb_err), 0);
        chk("rst_timeout", 32'(timeout_o), 0);
        chk("rst_ready", 32'(req_ready), 0);
        rst_n = 1'b1;

        // Single byte from requester 1
        push(1, 8'h41, 1'b1);
        wait_acc(1);
        wait_done(1);
        @(negedge clk);
        chk("t1_idx", acc_idx[0], 1);
        chk("t1_dat", acc_dat[0], 32'h41);
        chk("t1_one_ready", acc_n, 1);
        chk("t1_start_lat", start_cyc[0], acc_cyc[0] + 1);
        chk("t1_tx_data", start_dat[0], 32'h41);
        chk("t1_gnt_busy", start_gnt[0], 32'h2);
        chk("t1_gnt_free", 32'(gnt), 0);

        // Two single-byte requesters alternate
        do_reset();
        push(0, 8'hA0, 1'b1); push(0, 8'hA1, 1'b1);
        push(2, 8'hB0, 1'b1); push(2, 8'hB1, 1'b1);
        wait_done(4);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2_idx%0d", k), acc_idx[k], e2_idx[k]);
            chk($sformatf("t2_dat%0d", k), start_dat[k], e2_dat[k]);
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t2_next_acc%0d", k), acc_cyc[k+1], done_c[k] + 1);
        end
        chk("t2_starts", start_n, 4);
        chk("t2_dones", done_n, 4);

        // Locked three-byte message is not interleaved
        do_reset();
        push(3, 8'h10, 1'b0); push(3, 8'h11, 1'b0); push(3, 8'h12, 1'b1);
        wait_acc(1);
        push(0, 8'hC0, 1'b1);
        wait_done(4);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t3_idx%0d", k), acc_idx[k], e3_idx[k]);
            chk($sformatf("t3_dat%0d", k), start_dat[k], e3_dat[k]);
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t3_gnt%0d", k), start_gnt[k], 32'h8);
        end
        chk("t3_req0_after", acc_cyc[3], done_c[2] + 1);

        // Transmitter never goes busy
        do_reset();
        silent = 1'b1;
        push(1, 8'h55, 1'b1); push(2, 8'h66, 1'b1);
        wait_acc(2);
        repeat (25) @(negedge clk);
        silent = 1'b0;
        chk("t4_idx0", acc_idx[0], 1);
        chk("t4_idx1", acc_idx[1], 2);
        chk("t4_err_cyc", err_cyc, acc_cyc[0] + 18);
        chk("t4_next_acc", acc_cyc[1], acc_cyc[0] + 18);
        chk("t4_next_start", start_cyc[1], acc_cyc[1] + 1);
        chk("t4_err_sticky", 32'(arb_err), 1);

        // Reset in the middle of a byte
        do_reset();
        chk("t5_err_cleared", 32'(arb_err), 0);
        push(2, 8'h99, 1'b1);
        wait_done(1);
        push(1, 8'h77, 1'b1);
        wait_acc(2);
        push(3, 8'h88, 1'b1); push(2, 8'h9A, 1'b1);
        repeat (2) @(negedge clk);
        chk("t5_acc_idx", acc_idx[1], 1);
        chk("t5_gnt_before", 32'(gnt), 32'h2);
        rst_n = 1'b0;
        #1;
        chk("t5_gnt_rst", 32'(gnt), 0);
        chk("t5_start_rst", 32'(tx_start), 0);
        chk("t5_ready_rst", 32'(req_ready), 0);
        repeat (2) @(negedge clk);
        clr_logs();
        rst_n = 1'b1;
        wait_done(2);
        @(negedge clk);
        chk("t5_first_idx", acc_idx[0], 2);
        chk("t5_first_dat", start_dat[0], 32'h9A);
        chk("t5_second_idx", acc_idx[1], 3);
        chk("t5_second_dat", start_dat[1], 32'h88);

        // Owner stalls mid-message
        do_reset();
        push(2, 8'h22, 1'b0); push(3, 8'h33, 1'b1);
        wait_done(1);
        rr_r = done_c[0] + 1;
        repeat (2) @(negedge clk);
        chk("t6_idx0", acc_idx[0], 2);
        chk("t6_gnt_locked", 32'(gnt), 32'h4);
`ifdef UART_ARB_TIMEOUT_EN
        wait_acc(2);
        chk("t6_to_count", to_n, 1);
        chk("t6_to_cyc", to_cyc, rr_r + 8);
        chk("t6_req3_idx", acc_idx[1], 3);
        chk("t6_req3_cyc", acc_cyc[1], rr_r + 8);
        chk("t6_req3_dat", acc_dat[1], 32'h33);
        wait_done(2);
`else
        repeat (40) @(negedge clk);
        chk("t6_no_accept", acc_n, 1);
        chk("t6_no_timeout", to_n, 0);
        chk("t6_gnt_held", 32'(gnt), 32'h4);
        chk("t6_timeout_low", 32'(timeout_o), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
